// File: rtl/cgra_result_packer.sv
// Packs serial 64-bit CGRA results into 512-bit phits and streams them out
// through a 2-entry AXI4-Stream FIFO, marking TLAST on the final phit of a vector.
module cgra_result_packer #(
   parameter int dwidth_double = 64,
   parameter int SIMD_degree   = 8,
   parameter int phit_size     = 512,
   parameter int dwidth_int    = 32
) (
   input  logic                     axis_aclk,
   input  logic                     axis_resetn,
   input  logic                     start,
   input  logic [dwidth_int-1:0]    num_words,
   input  logic                     res_valid,
   input  logic [dwidth_double-1:0] res_data,
   output logic                     res_ready,
   output logic [phit_size-1:0]     m_axis_tdata,
   output logic [phit_size/8-1:0]   m_axis_tkeep,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic                     m_axis_tlast,
   output logic                     busy,
   output logic                     done
);

   localparam int LANE_W    = (SIMD_degree > 1) ? $clog2(SIMD_degree) : 1;
   localparam int KEEP_W    = phit_size / 8;
   localparam int LANE_KEEP = dwidth_double / 8;
   localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(SIMD_degree - 1);

   typedef enum logic [1:0] {IDLE, PACK, DRAIN} state_t;

   state_t                  state;
   logic [dwidth_int-1:0]   words_left;
   logic [LANE_W-1:0]       lane_idx;
   logic [phit_size-1:0]    asm_data;
   logic [KEEP_W-1:0]       asm_keep;

   logic [phit_size-1:0]    fifo_data [2];
   logic [KEEP_W-1:0]       fifo_keep [2];
   logic [1:0]              fifo_last;
   logic                    wr_ptr;
   logic                    rd_ptr;
   logic [1:0]              fifo_count;

   logic                    accept;
   logic                    last_word;
   logic                    phit_done;
   logic                    pop;
   int                      lane_int;
   logic [phit_size-1:0]    merged_data;
   logic [KEEP_W-1:0]       merged_keep;

   assign res_ready = (state == PACK) && (fifo_count < 2'd2);
   assign accept    = res_valid && res_ready;
   assign last_word = (words_left == dwidth_int'(1));
   assign phit_done = accept && ((lane_idx == LAST_LANE) || last_word);

   assign m_axis_tvalid = (fifo_count != 2'd0);
   assign m_axis_tdata  = fifo_data[rd_ptr];
   assign m_axis_tkeep  = fifo_keep[rd_ptr];
   assign m_axis_tlast  = fifo_last[rd_ptr];
   assign pop           = m_axis_tvalid && m_axis_tready;

   // The incoming word merged into its lane; this is what gets pushed when a phit closes.
   always_comb begin
      lane_int    = int'(lane_idx);
      merged_data = asm_data;
      merged_keep = asm_keep;
      merged_data[lane_int*dwidth_double +: dwidth_double] = res_data;
      merged_keep[lane_int*LANE_KEEP +: LANE_KEEP]         = '1;
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         state      <= IDLE;
         words_left <= '0;
         lane_idx   <= '0;
         asm_data   <= '0;
         asm_keep   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (num_words != '0) begin
                     words_left <= num_words;
                     lane_idx   <= '0;
                     busy       <= 1'b1;
                     state      <= PACK;
                  end else begin
                     done <= 1'b1;
                  end
               end
            end
            PACK: begin
               if (accept) begin
                  words_left <= words_left - dwidth_int'(1);
                  if (phit_done) begin
                     asm_data <= '0;
                     asm_keep <= '0;
                     lane_idx <= '0;
                  end else begin
                     asm_data <= merged_data;
                     asm_keep <= merged_keep;
                     lane_idx <= lane_idx + LANE_W'(1);
                  end
                  if (last_word) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && m_axis_tlast) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // res_ready is gated on fifo_count, so a push never lands on a full FIFO.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_keep[0] <= '0;
         fifo_keep[1] <= '0;
         fifo_last    <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_count   <= '0;
      end else begin
         if (phit_done) begin
            fifo_data[wr_ptr] <= merged_data;
            fifo_keep[wr_ptr] <= merged_keep;
            fifo_last[wr_ptr] <= last_word;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({phit_done, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: doc/cgra_result_packer.md
Name: cgra_result_packer

Overview:
- Transmit-side counterpart of the CGRA data channel. It collects the serial 64-bit double results (out1) from the last PE column and packs SIMD_degree results per 512-bit phit.
- Packed phits go out on an AXI4-Stream master toward the NetFPGA datapath.
- The output stage is a 2-entry FIFO, and TLAST is marked on the final phit of a configured vector length.
- Sits between the CGRA column array and the egress stream.

Parameters:
- dwidth_double, 64, width of one result word.
- SIMD_degree, 8, result words per phit.
- phit_size, 512, stream data width; must equal dwidth_double*SIMD_degree.
- dwidth_int, 32, width of the vector-length field.

Ports:
- axis_aclk  in  1  single clock; all logic on its rising edge.
- axis_resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a vector.
- num_words  in  dwidth_int  vector length in result words; sampled on start.
- res_valid  in  1  result word valid.
- res_data  in  dwidth_double  result word (PE out1).
- res_ready  out  1  packer accepts res_data this cycle.
- m_axis_tdata  out  phit_size  packed phit.
- m_axis_tkeep  out  phit_size/8  byte enables.
- m_axis_tvalid  out  1  phit valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  final phit of vector.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse on final phit handshake.

Behaviour:
Reset:
- All outputs 0; state IDLE; FIFO empty; lane index, word counter and assembly register cleared.
- Reset asserted mid-vector discards the partial phit and all FIFO contents; no done pulse is generated.

State machine (IDLE, PACK, DRAIN):
- IDLE, start=1, num_words>0: latch num_words into words_left, lane_idx=0, go to PACK, busy=1 next cycle.
- IDLE, start=1, num_words=0: done pulses next cycle; stay IDLE; busy stays 0; no phit emitted.
- PACK: res_ready = (fifo_count<2). A word is accepted when res_valid && res_ready.
- Each accepted word is written into lane lane_idx, bits [64*lane_idx+63 : 64*lane_idx]. Lane 0 is the first word. Then lane_idx increments and words_left decrements.
- A phit completes when lane_idx=SIMD_degree-1 or words_left=1 at acceptance. On completion:
  - Push {data, keep, last} into the FIFO the same edge.
  - keep = 8 ones per filled lane; unfilled lanes have data 0 and keep 0.
  - last = (words_left==1).
  - Clear the assembly register and reset lane_idx to 0.
- PACK to DRAIN when the last word is accepted.
- DRAIN: res_ready=0. When the tlast phit handshakes (tvalid && tready && tlast): done=1 for one cycle, busy=0, go to IDLE.
- start is ignored while busy=1.

Output FIFO:
- 2 entries; head drives m_axis_*; tvalid = (fifo_count>0).
- Head pops on tvalid && tready.
- A simultaneous push and pop keeps fifo_count unchanged.
- Output data stays stable while tvalid=1 && tready=0.

Timing and throughput:
- Word completing a phit at edge N: m_axis_tvalid=1 in cycle N+1 (1-cycle latency).
- Sustained 1 word/cycle with tready held high; no bubbles between phits.
- res_valid while not in PACK: res_ready=0, word not consumed.
- Backpressure: with the FIFO full, res_ready drops. Assembly of a new phit resumes once fifo_count<2, with no loss or duplication.

Width rules:
- words_left is dwidth_int wide; no wrap occurs because of the num_words>0 check.
- lane_idx is $clog2(SIMD_degree) bits.

Test Plan:
1. num_words=16, words 1..16 back-to-back, tready=1 -> 2 phits.
   - Phit0 lane0=1 … lane7=8, tkeep=all ones, tlast=0.
   - Phit1 lanes 9..16, tlast=1.
   - Phit0 tvalid one cycle after the 8th word; done pulses on phit1 handshake; busy 0 afterward.
2. num_words=11, words 0xA0..0xAA -> phit1 lanes0–2 = 0xA8,0xA9,0xAA, lanes3–7 = 0, tkeep=0x0000_0000_00FF_FFFF, tlast=1.
3. num_words=32, tready=0 for 20 cycles, then 1 -> res_ready drops after 2 phits are queued.
   - All 4 phits delivered in order with correct data, one done pulse.
4. start with num_words=0 -> no tvalid, done pulses exactly one cycle after start, busy stays 0.
5. Reset asserted (axis_resetn=0) after 5 of 16 words, released, new start num_words=8 -> only the new 8-word phit appears, tlast=1, no stale lanes.
6. Second start pulse during an active 16-word vector -> ignored; exactly 2 phits and 1 done pulse.
